// File: rtl/shiftadd_mac_fx.sv
`timescale 1ns/1ps
// Radix-2 shift-and-add signed multiplier with valid/ready handshake.
// Produces a full 2W-bit product and a rounded, FRAC-shifted, saturated W-bit result.
module shiftadd_mac_fx #(
  parameter int W         = 16,
  parameter int FRAC      = 0,
  parameter int ZERO_SKIP = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic [W-1:0]   q,
  output logic           ovf
);

  localparam int CW = $clog2(W + 1);
  localparam logic [2*W:0] HALF = ((2*W+1)'(1) << FRAC) >> 1;
  localparam logic signed [2*W:0] Q_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] Q_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    mplr_q, mplr_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            neg_q, neg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  p_q, p_d;
  logic [W-1:0]    q_q, q_d;
  logic            ovf_q, ovf_d;

  logic [W:0]             sum;
  logic [2*W-1:0]         mag;
  logic [2*W-1:0]         p_fix;
  logic signed [2*W:0]    r_s;
  logic signed [2*W:0]    s_s;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    ovf_d   = ovf_q;

    sum   = {1'b0, acc_q} + {1'b0, (mplr_q[0] ? mcand_q : {W{1'b0}})};
    mag   = {acc_q, mplr_q};
    p_fix = neg_q ? -mag : mag;
    r_s   = $signed({p_fix[2*W-1], p_fix}) + $signed(HALF);
    s_s   = r_s >>> FRAC;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a[W-1] ? -a : a;
          mplr_d  = b[W-1] ? -b : b;
          neg_d   = a[W-1] ^ b[W-1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Two zero multiplier bits need no add, so both can be retired in one step.
        if (ZERO_SKIP != 0 && mplr_q[1:0] == 2'b00 && cnt_q <= CW'(W - 2)) begin
          {acc_d, mplr_d} = {2'b00, acc_q, mplr_q[W-1:2]};
          cnt_d = cnt_q + CW'(2);
        end else begin
          {acc_d, mplr_d} = {sum, mplr_q[W-1:1]};
          cnt_d = cnt_q + CW'(1);
        end
        if (cnt_d == CW'(W)) state_d = FIX;
      end
      FIX: begin
        p_d = p_fix;
        if (s_s > Q_MAX) begin
          q_d   = Q_MAX[W-1:0];
          ovf_d = 1'b1;
        end else if (s_s < Q_MIN) begin
          q_d   = Q_MIN[W-1:0];
          ovf_d = 1'b1;
        end else begin
          q_d   = s_s[W-1:0];
          ovf_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;
  assign q         = q_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_shiftadd_mac_fx.sv
`timescale 1ns/1ps
// Self-checking bench: two instances (FRAC=0/no skip, FRAC=8/skip) driven from a vector
// table, hand-written handshake/reset sequences and random operands against a reference model.
module tb_shiftadd_mac_fx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_s [2];
  logic        in_ready_s [2];
  logic [15:0] a_s        [2];
  logic [15:0] b_s        [2];
  logic        out_valid_s[2];
  logic        out_ready_s[2];
  logic [31:0] p_s        [2];
  logic [15:0] q_s        [2];
  logic        ovf_s      [2];

  int n_vec = 0;
  int n_err = 0;

  localparam int FRAC_OF[2] = '{0, 8};
  localparam int ZS_OF[2]   = '{0, 1};

  always #5 clk = ~clk;

  shiftadd_mac_fx #(.W(16), .FRAC(0), .ZERO_SKIP(0)) dut0 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a_s[0]), .b(b_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .p(p_s[0]), .q(q_s[0]), .ovf(ovf_s[0])
  );

  shiftadd_mac_fx #(.W(16), .FRAC(8), .ZERO_SKIP(1)) dut1 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a_s[1]), .b(b_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .p(p_s[1]), .q(q_s[1]), .ovf(ovf_s[1])
  );

  typedef struct {
    int          d;
    logic [15:0] a;
    logic [15:0] b;
    longint      p;
    longint      q;
    logic        ovf;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Arithmetic reference: exact product, round-half-up shift, clamp; latency from bit scan of |b|.
  task automatic ref_model(input logic [15:0] av, input logic [15:0] bv, input int d,
                           output longint pe, output longint qe, output logic oe, output int le);
    longint r;
    longint s;
    int     v;
    int     rem;
    int     steps;
    pe = longint'($signed(av)) * longint'($signed(bv));
    r  = pe;
    if (FRAC_OF[d] > 0) r = r + (longint'(1) << (FRAC_OF[d] - 1));
    s = r >>> FRAC_OF[d];
    if (s > 32767) begin
      qe = 32767; oe = 1'b1;
    end else if (s < -32768) begin
      qe = -32768; oe = 1'b1;
    end else begin
      qe = s; oe = 1'b0;
    end
    v = int'($signed(bv));
    if (v < 0) v = -v;
    rem = 16;
    steps = 0;
    while (rem > 0) begin
      if (ZS_OF[d] != 0 && (v % 4) == 0 && rem >= 2) begin
        v = v / 4; rem = rem - 2;
      end else begin
        v = v / 2; rem = rem - 1;
      end
      steps++;
    end
    le = steps + 1;
  endtask

  task automatic start_op(input int d, input logic [15:0] av, input logic [15:0] bv);
    int guard = 0;
    @(negedge clk);
    while (!in_ready_s[d] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("in_ready_timeout", 0, 1);
    in_valid_s[d] = 1'b1;
    a_s[d] = av;
    b_s[d] = bv;
    @(posedge clk);
    #1 in_valid_s[d] = 1'b0;
  endtask

  task automatic wait_result(input int d, output int lat);
    lat = 0;
    while (!out_valid_s[d] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op(input int d);
    @(negedge clk);
    out_ready_s[d] = 1'b1;
    @(posedge clk);
    #1 out_ready_s[d] = 1'b0;
  endtask

  task automatic check_op(input int d, input logic [15:0] av, input logic [15:0] bv,
                          input longint pe, input longint qe, input logic oe, input int le);
    int lat;
    start_op(d, av, bv);
    wait_result(d, lat);
    $display("op dut%0d a=%h b=%h -> p=%h q=%h ovf=%b lat=%0d", d, av, bv, p_s[d], q_s[d], ovf_s[d], lat);
    chk("latency", lat, le);
    chk("p", longint'($signed(p_s[d])), pe);
    chk("q", longint'($signed(q_s[d])), qe);
    chk("ovf", longint'(ovf_s[d]), longint'(oe));
    finish_op(d);
  endtask

  vec_t vecs[$];

  initial begin
    longint pe, qe;
    logic   oe;
    int     le;
    int     lat;
    int     seen;
    logic [15:0] ra, rb;

    for (int i = 0; i < 2; i++) begin
      in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b0; a_s[i] = '0; b_s[i] = '0;
    end

    vecs.push_back('{0, 16'd3,    16'hFFFB, -15,          -15,    1'b0, 17});
    vecs.push_back('{0, 16'h8000, 16'h8000, 1073741824,   32767,  1'b1, 17});
    vecs.push_back('{0, 16'h7FFF, 16'h8000, -1073709056,  -32768, 1'b1, 17});
    vecs.push_back('{1, 16'h0180, 16'h0200, 196608,       768,    1'b0, 10});
    vecs.push_back('{1, 16'h0001, 16'h0080, 128,          1,      1'b0, 10});
    vecs.push_back('{1, 16'hFFFF, 16'h0080, -128,         0,      1'b0, 10});
    vecs.push_back('{1, 16'h0005, 16'h0000, 0,            0,      1'b0, 9});
    vecs.push_back('{0, 16'h0005, 16'h0000, 0,            0,      1'b0, 17});
    vecs.push_back('{1, 16'h1234, 16'h8001, -152694220,   -32768, 1'b1, 17});
    vecs.push_back('{1, 16'h7FFF, 16'h7FFF, 1073676289,   32767,  1'b1, 17});

    // Reset state
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_p", longint'(p_s[d]), 0);
      chk("rst_q", longint'(q_s[d]), 0);
      chk("rst_ovf", longint'(ovf_s[d]), 0);
      chk("rst_out_valid", longint'(out_valid_s[d]), 0);
      chk("rst_in_ready", longint'(in_ready_s[d]), 1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      check_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].q, vecs[i].ovf, vecs[i].lat);

    // Consumer stall: result and busy status held while out_ready is low
    start_op(0, 16'd3, 16'hFFFB);
    wait_result(0, lat);
    chk("stall_latency", lat, 17);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      $display("stall cycle %0d: out_valid=%b in_ready=%b p=%h", c, out_valid_s[0], in_ready_s[0], p_s[0]);
      chk("stall_out_valid", longint'(out_valid_s[0]), 1);
      chk("stall_in_ready", longint'(in_ready_s[0]), 0);
      chk("stall_p", longint'($signed(p_s[0])), -15);
      chk("stall_q", longint'($signed(q_s[0])), -15);
    end
    finish_op(0);
    chk("post_hs_out_valid", longint'(out_valid_s[0]), 0);
    chk("post_hs_in_ready", longint'(in_ready_s[0]), 1);
    chk("post_hs_p_held", longint'($signed(p_s[0])), -15);
    check_op(0, 16'd2, 16'd9, 18, 18, 1'b0, 17);

    // Asynchronous reset in the middle of RUN
    start_op(0, 16'd100, 16'd200);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("mid-run reset: out_valid=%b in_ready=%b p=%h q=%h", out_valid_s[0], in_ready_s[0], p_s[0], q_s[0]);
    chk("arst_p", longint'(p_s[0]), 0);
    chk("arst_q", longint'(q_s[0]), 0);
    chk("arst_out_valid", longint'(out_valid_s[0]), 0);
    chk("arst_in_ready", longint'(in_ready_s[0]), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid_s[0]) seen++;
    end
    chk("aborted_no_result", seen, 0);
    chk("post_rst_in_ready", longint'(in_ready_s[0]), 1);
    check_op(0, 16'd7, 16'd7, 49, 49, 1'b0, 17);

    // Random operands against the reference model
    for (int i = 0; i < 40; i++) begin
      int d;
      d  = i % 2;
      ra = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 16'h0000;
        1:       rb = 16'h8000;
        2:       rb = 16'($urandom) & 16'h0F00;
        3:       rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      ref_model(ra, rb, d, pe, qe, oe, le);
      check_op(d, ra, rb, pe, qe, oe, le);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
